// File: rtl/cdb_arbiter_if.sv
// Result-bus bundle for cdb_arbiter: three FU push channels plus the registered CDB broadcast.
// The slave modport is the arbiter's view; the master modport is the FU and consumer side.
interface cdb_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4
);
  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [XLEN-1:0]   alu_data_i;
  logic [PREG_W-1:0] alu_preg_i;
  logic [ROB_W-1:0]  alu_rob_tag_i;

  logic              lsu_valid_i;
  logic              lsu_ready_o;
  logic [XLEN-1:0]   lsu_data_i;
  logic [PREG_W-1:0] lsu_preg_i;
  logic [ROB_W-1:0]  lsu_rob_tag_i;

  logic              br_valid_i;
  logic              br_ready_o;
  logic [XLEN-1:0]   br_data_i;
  logic [PREG_W-1:0] br_preg_i;
  logic [ROB_W-1:0]  br_rob_tag_i;
  logic              br_mispredict_i;
  logic [XLEN-1:0]   br_target_i;

  logic              cdb_valid_o;
  logic [XLEN-1:0]   cdb_data_o;
  logic [PREG_W-1:0] cdb_preg_o;
  logic [ROB_W-1:0]  cdb_rob_tag_o;
  logic              cdb_mispredict_o;
  logic [XLEN-1:0]   cdb_target_o;
  logic [1:0]        cdb_src_o;

  modport master (
    output alu_valid_i, alu_data_i, alu_preg_i, alu_rob_tag_i,
    output lsu_valid_i, lsu_data_i, lsu_preg_i, lsu_rob_tag_i,
    output br_valid_i, br_data_i, br_preg_i, br_rob_tag_i, br_mispredict_i, br_target_i,
    input  alu_ready_o, lsu_ready_o, br_ready_o,
    input  cdb_valid_o, cdb_data_o, cdb_preg_o, cdb_rob_tag_o,
    input  cdb_mispredict_o, cdb_target_o, cdb_src_o
  );

  modport slave (
    input  alu_valid_i, alu_data_i, alu_preg_i, alu_rob_tag_i,
    input  lsu_valid_i, lsu_data_i, lsu_preg_i, lsu_rob_tag_i,
    input  br_valid_i, br_data_i, br_preg_i, br_rob_tag_i, br_mispredict_i, br_target_i,
    output alu_ready_o, lsu_ready_o, br_ready_o,
    output cdb_valid_o, cdb_data_o, cdb_preg_o, cdb_rob_tag_o,
    output cdb_mispredict_o, cdb_target_o, cdb_src_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs, round-robin pick with optional branch priority,
// registered CDB broadcast. Handshake: an FU entry transfers on the clk edge where valid && ready.
module cdb_arbiter #(
  parameter int XLEN        = 32,
  parameter int PREG_W      = 6,
  parameter int ROB_W       = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int BR_PRIORITY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSU = 2'd1;
  localparam logic [1:0] SRC_BR  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [PREG_W-1:0] preg;
    logic [ROB_W-1:0]  rob_tag;
    logic              mispredict;
    logic [XLEN-1:0]   target;
  } entry_t;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC_BR) ? SRC_ALU : s + 2'd1;
  endfunction

  entry_t           mem    [3][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr [3];
  logic [PTR_W-1:0] wr_ptr [3];
  logic [CNT_W-1:0] count  [3];
  logic [1:0]       rr_ptr;

  entry_t     in_entry [3];
  logic [2:0] valid_in;
  logic [2:0] ready;
  logic [2:0] not_empty;
  logic [2:0] push;
  logic [2:0] pop;
  logic       grant_valid;
  logic [1:0] grant_src;
  logic [1:0] cand;
  entry_t     head;

  entry_t     cdb_q;
  logic       cdb_valid;
  logic [1:0] cdb_src;

  // Only branch entries carry a mispredict flag and target; the others broadcast zeros there.
  always_comb begin
    in_entry[0] = '{data: bus.alu_data_i, preg: bus.alu_preg_i, rob_tag: bus.alu_rob_tag_i,
                    mispredict: 1'b0, target: '0};
    in_entry[1] = '{data: bus.lsu_data_i, preg: bus.lsu_preg_i, rob_tag: bus.lsu_rob_tag_i,
                    mispredict: 1'b0, target: '0};
    in_entry[2] = '{data: bus.br_data_i, preg: bus.br_preg_i, rob_tag: bus.br_rob_tag_i,
                    mispredict: bus.br_mispredict_i, target: bus.br_target_i};
  end

  assign valid_in = {bus.br_valid_i, bus.lsu_valid_i, bus.alu_valid_i};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ready[i]     = count[i] < CNT_W'(FIFO_DEPTH);
      not_empty[i] = count[i] != '0;
    end
  end

  assign push = valid_in & ready;

  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    cand        = rr_ptr;
    if (BR_PRIORITY != 0 && not_empty[SRC_BR]) begin
      grant_valid = 1'b1;
      grant_src   = SRC_BR;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!grant_valid && not_empty[cand]) begin
          grant_valid = 1'b1;
          grant_src   = cand;
        end
        cand = next_src(cand);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pop[i] = grant_valid && (grant_src == 2'(i));
    end
  end

  always_comb begin
    case (grant_src)
      SRC_LSU: head = mem[1][rd_ptr[1]];
      SRC_BR:  head = mem[2][rd_ptr[2]];
      default: head = mem[0][rd_ptr[0]];
    endcase
  end

  // Flush discards queued entries and this cycle's pushes; the CDB fields keep their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr    <= SRC_ALU;
      cdb_valid <= 1'b0;
      cdb_q     <= '0;
      cdb_src   <= SRC_ALU;
    end else if (flush_i) begin
      for (int i = 0; i < 3; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr    <= SRC_ALU;
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= in_entry[i];
          wr_ptr[i]         <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_q   <= head;
        cdb_src <= grant_src;
        rr_ptr  <= next_src(grant_src);
      end
    end
  end

  assign bus.alu_ready_o      = ready[0];
  assign bus.lsu_ready_o      = ready[1];
  assign bus.br_ready_o       = ready[2];
  assign bus.cdb_valid_o      = cdb_valid;
  assign bus.cdb_data_o       = cdb_q.data;
  assign bus.cdb_preg_o       = cdb_q.preg;
  assign bus.cdb_rob_tag_o    = cdb_q.rob_tag;
  assign bus.cdb_mispredict_o = cdb_q.mispredict;
  assign bus.cdb_target_o     = cdb_q.target;
  assign bus.cdb_src_o        = cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a branch-priority instance and a pure round-robin instance share one
// stimulus stream; a queue-based model of the result flow predicts every output each cycle.
module tb_cdb_arbiter;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        alu_v, lsu_v, br_v, br_m;
  logic [31:0] alu_d, lsu_d, br_d, br_tg;
  logic [5:0]  alu_p, lsu_p, br_p;
  logic [3:0]  alu_t, lsu_t, br_t;

  cdb_arbiter_if #(.XLEN(32), .PREG_W(6), .ROB_W(4)) bus_pri ();
  cdb_arbiter_if #(.XLEN(32), .PREG_W(6), .ROB_W(4)) bus_rr ();

  cdb_arbiter #(.XLEN(32), .PREG_W(6), .ROB_W(4), .FIFO_DEPTH(DEPTH), .BR_PRIORITY(1)) u_dut_pri (
    .clk(clk), .reset(rst), .flush_i(flush), .bus(bus_pri.slave)
  );
  cdb_arbiter #(.XLEN(32), .PREG_W(6), .ROB_W(4), .FIFO_DEPTH(DEPTH), .BR_PRIORITY(0)) u_dut_rr (
    .clk(clk), .reset(rst), .flush_i(flush), .bus(bus_rr.slave)
  );

  always_comb begin
    bus_pri.alu_valid_i = alu_v;  bus_rr.alu_valid_i = alu_v;
    bus_pri.alu_data_i  = alu_d;  bus_rr.alu_data_i  = alu_d;
    bus_pri.alu_preg_i  = alu_p;  bus_rr.alu_preg_i  = alu_p;
    bus_pri.alu_rob_tag_i = alu_t; bus_rr.alu_rob_tag_i = alu_t;
    bus_pri.lsu_valid_i = lsu_v;  bus_rr.lsu_valid_i = lsu_v;
    bus_pri.lsu_data_i  = lsu_d;  bus_rr.lsu_data_i  = lsu_d;
    bus_pri.lsu_preg_i  = lsu_p;  bus_rr.lsu_preg_i  = lsu_p;
    bus_pri.lsu_rob_tag_i = lsu_t; bus_rr.lsu_rob_tag_i = lsu_t;
    bus_pri.br_valid_i  = br_v;   bus_rr.br_valid_i  = br_v;
    bus_pri.br_data_i   = br_d;   bus_rr.br_data_i   = br_d;
    bus_pri.br_preg_i   = br_p;   bus_rr.br_preg_i   = br_p;
    bus_pri.br_rob_tag_i = br_t;  bus_rr.br_rob_tag_i = br_t;
    bus_pri.br_mispredict_i = br_m; bus_rr.br_mispredict_i = br_m;
    bus_pri.br_target_i = br_tg;  bus_rr.br_target_i = br_tg;
  end

  int n_vectors;
  int n_miscompares;

  // Reference model: one queue of packed {data, preg, tag, mispredict, target} per source per
  // instance (index d*3+src, d=0 branch-priority, d=1 round-robin) and the expected CDB contents.
  logic [74:0] exp_q [6][$];
  int          rr_m   [2];
  logic        exp_v  [2];
  logic [31:0] exp_d  [2];
  logic [5:0]  exp_p  [2];
  logic [3:0]  exp_t  [2];
  logic        exp_m  [2];
  logic [31:0] exp_tg [2];
  logic [1:0]  exp_s  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [74:0] ins [3];
    logic        vin [3];
    bit          acc [3];
    logic [74:0] e;
    int          g, s;
    ins[0] = {alu_d, alu_p, alu_t, 1'b0, 32'h0};
    ins[1] = {lsu_d, lsu_p, lsu_t, 1'b0, 32'h0};
    ins[2] = {br_d, br_p, br_t, br_m, br_tg};
    vin[0] = alu_v; vin[1] = lsu_v; vin[2] = br_v;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) acc[k] = vin[k] && (exp_q[d*3+k].size() < DEPTH);
      if (rst) begin
        for (int k = 0; k < 3; k++) exp_q[d*3+k].delete();
        rr_m[d] = 0; exp_v[d] = 1'b0; exp_d[d] = '0; exp_p[d] = '0;
        exp_t[d] = '0; exp_m[d] = 1'b0; exp_tg[d] = '0; exp_s[d] = '0;
      end else if (flush) begin
        for (int k = 0; k < 3; k++) exp_q[d*3+k].delete();
        rr_m[d] = 0; exp_v[d] = 1'b0;
      end else begin
        g = -1;
        if (d == 0 && exp_q[d*3+2].size() > 0) g = 2;
        else begin
          for (int k = 0; k < 3; k++) begin
            s = (rr_m[d] + k) % 3;
            if (g < 0 && exp_q[d*3+s].size() > 0) g = s;
          end
        end
        if (g >= 0) begin
          e = exp_q[d*3+g].pop_front();
          {exp_d[d], exp_p[d], exp_t[d], exp_m[d], exp_tg[d]} = e;
          exp_s[d] = 2'(g);
          rr_m[d]  = (g + 1) % 3;
          exp_v[d] = 1'b1;
        end else begin
          exp_v[d] = 1'b0;
        end
        for (int k = 0; k < 3; k++) if (acc[k]) exp_q[d*3+k].push_back(ins[k]);
      end
    end
  endtask

  task automatic compare_dut(input int d, input string nm, input logic v, input logic [31:0] data,
                             input logic [5:0] preg, input logic [3:0] tag, input logic m,
                             input logic [31:0] tg, input logic [1:0] src,
                             input logic ar, input logic lr, input logic br);
    check({nm, ".valid"}, v, exp_v[d]);
    check({nm, ".data"}, data, exp_d[d]);
    check({nm, ".preg"}, preg, exp_p[d]);
    check({nm, ".tag"}, tag, exp_t[d]);
    check({nm, ".mispredict"}, m, exp_m[d]);
    check({nm, ".target"}, tg, exp_tg[d]);
    check({nm, ".src"}, src, exp_s[d]);
    check({nm, ".alu_ready"}, ar, exp_q[d*3+0].size() < DEPTH);
    check({nm, ".lsu_ready"}, lr, exp_q[d*3+1].size() < DEPTH);
    check({nm, ".br_ready"}, br, exp_q[d*3+2].size() < DEPTH);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_dut(0, "pri", bus_pri.cdb_valid_o, bus_pri.cdb_data_o, bus_pri.cdb_preg_o,
                bus_pri.cdb_rob_tag_o, bus_pri.cdb_mispredict_o, bus_pri.cdb_target_o,
                bus_pri.cdb_src_o, bus_pri.alu_ready_o, bus_pri.lsu_ready_o, bus_pri.br_ready_o);
    compare_dut(1, "rr", bus_rr.cdb_valid_o, bus_rr.cdb_data_o, bus_rr.cdb_preg_o,
                bus_rr.cdb_rob_tag_o, bus_rr.cdb_mispredict_o, bus_rr.cdb_target_o,
                bus_rr.cdb_src_o, bus_rr.alu_ready_o, bus_rr.lsu_ready_o, bus_rr.br_ready_o);
  endtask

  task automatic rand_fields();
    alu_d = $urandom(); alu_p = 6'($urandom_range(0, 63)); alu_t = 4'($urandom_range(0, 15));
    lsu_d = $urandom(); lsu_p = 6'($urandom_range(0, 63)); lsu_t = 4'($urandom_range(0, 15));
    br_d  = $urandom(); br_p  = 6'($urandom_range(0, 63)); br_t  = 4'($urandom_range(0, 15));
    br_m  = 1'($urandom_range(0, 1)); br_tg = $urandom();
  endtask

  task automatic idle_inputs();
    alu_v = 1'b0; lsu_v = 1'b0; br_v = 1'b0; flush = 1'b0;
    rand_fields();
  endtask

  initial begin
    n_vectors = 0;
    n_miscompares = 0;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Single ALU result: two edges from push to broadcast, then one-cycle valid.
    alu_v = 1'b1; alu_d = 32'h0000_002A; alu_p = 6'd5; alu_t = 4'd3;
    tick();
    alu_v = 1'b0;
    tick();
    check("single.valid", bus_pri.cdb_valid_o, 1);
    check("single.data", bus_pri.cdb_data_o, 32'h2A);
    check("single.preg", bus_pri.cdb_preg_o, 5);
    check("single.tag", bus_pri.cdb_rob_tag_o, 3);
    check("single.src", bus_pri.cdb_src_o, 0);
    check("single.target", bus_pri.cdb_target_o, 0);
    tick();
    check("single.gap", bus_pri.cdb_valid_o, 0);

    // All three push together, then ALU and LSU again.
    rand_fields(); alu_v = 1'b1; lsu_v = 1'b1; br_v = 1'b1;
    tick();
    idle_inputs();
    repeat (3) tick();
    alu_v = 1'b1; lsu_v = 1'b1;
    tick();
    idle_inputs();
    repeat (3) tick();

    // Branch overtakes a continuous ALU stream on the priority instance.
    alu_v = 1'b1;
    repeat (3) begin rand_fields(); tick(); end
    rand_fields(); br_v = 1'b1; br_t = 4'd7; br_m = 1'b1; br_tg = 32'h8000_0100;
    tick();
    br_v = 1'b0; rand_fields();
    tick();
    check("brpri.src", bus_pri.cdb_src_o, 2);
    check("brpri.mispredict", bus_pri.cdb_mispredict_o, 1);
    check("brpri.target", bus_pri.cdb_target_o, 32'h8000_0100);
    repeat (3) begin rand_fields(); tick(); end
    idle_inputs();
    repeat (4) tick();

    // LSU backpressure while branches flood the bus.
    lsu_v = 1'b1; br_v = 1'b1;
    for (int i = 0; i < 6; i++) begin rand_fields(); lsu_t = 4'(i); tick(); end
    br_v = 1'b0;
    for (int i = 6; i < 12; i++) begin rand_fields(); lsu_t = 4'(i); tick(); end
    idle_inputs();
    repeat (4) tick();

    // Flush with queued entries and a flush-cycle push.
    alu_v = 1'b1; lsu_v = 1'b1;
    tick();
    lsu_v = 1'b0; rand_fields();
    tick();
    flush = 1'b1; rand_fields();
    tick();
    idle_inputs();
    tick();
    check("flush.valid", bus_pri.cdb_valid_o, 0);
    check("flush.alu_ready", bus_pri.alu_ready_o, 1);
    alu_v = 1'b1;
    tick();
    alu_v = 1'b0;
    tick();
    check("flush.next_valid", bus_rr.cdb_valid_o, 1);
    check("flush.next_src", bus_rr.cdb_src_o, 0);

    // Reset while every FIFO holds entries.
    alu_v = 1'b1; lsu_v = 1'b1; br_v = 1'b1;
    repeat (2) begin rand_fields(); tick(); end
    rst = 1'b1; idle_inputs();
    tick();
    rst = 1'b0;
    check("midreset.data", bus_rr.cdb_data_o, 0);
    repeat (3) tick();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      rand_fields();
      alu_v = ($urandom_range(0, 99) < 55);
      lsu_v = ($urandom_range(0, 99) < 55);
      br_v  = ($urandom_range(0, 99) < 35);
      flush = ($urandom_range(0, 99) < 3);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; idle_inputs();
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
